muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multi-cycle multiply/divide unit with HI/LO result registers for the MIPS datapath. It sits beside the single-cycle `alu`. The `alu` produces results combinationally from operands; this block consumes a start request, runs one shift-add or shift-subtract step per cycle, and returns results through a done/busy handshake. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO semantics.

## Interface
Parameters:
- `width`, 32, operand width; HI and LO are each `width` bits.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`, `b`  in  width  operands; `a` is the multiplicand or dividend, `b` is the multiplier or divisor; sampled with `start`.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `wdata`  in  width  data for MTHI/MTLO.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI and LO hold the new result in that cycle.
- `hi`, `lo`  out  width  result registers. Multiply: high/low product. Divide: remainder/quotient.
- `div_by_zero`  out  1  set with `done` for a divide with `b`=0; held until the next accepted `start`.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE + `start`: latch `op` and the magnitudes of `a` and `b`.
  - Magnitudes are two's-complement absolute values for signed ops and raw values for unsigned ops.
  - Latch the sign bits and clear the step counter. Go to RUN.
- RUN lasts exactly `width` cycles, one step per cycle.
  - Multiply: unsigned shift-add over a 2*`width` accumulator, LSB-first on the multiplier.
  - Divide: restoring shift-subtract, producing one quotient bit per cycle, MSB-first.
  - After step `width`-1, go to FINISH.
- FINISH, one cycle: sign fix-up, then write HI/LO, pulse `done`, return to IDLE.
  - Signed multiply: negate the 2*`width` product when the operand signs differ.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - All sign arithmetic is modulo 2^`width` (2^(2*`width`) for the product).
  - Consequence: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0, with no flag.
- Divide by zero (`b`=0, DIV or DIVU):
  - Sign fix-up is skipped: LO=all ones, HI=original `a`.
  - `div_by_zero`=1. RUN still takes the full `width` cycles (fixed latency).
- MTHI/MTLO: while IDLE and `start`=0, `hi_we`/`lo_we` write `wdata` into HI/LO at the next edge.
  - Both enables may be active together.
  - Writes are ignored while busy and in any cycle where `start` is accepted (start wins).
- `start` while busy is ignored; no queueing.
- HI/LO are not modified between acceptance and FINISH; they show the previous result until `done`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0.
- Reset during RUN or FINISH aborts the operation. No HI/LO write and no `done` pulse; all outputs return to their reset values.
- Latency: `start` sampled at edge E0 → `busy`=1 from E0 through E(`width`+1) → at edge E(`width`+1) HI/LO update, `done`=1 and `busy`=0 for one cycle.
  - Total latency is `width`+1 cycles (33 for `width`=32).
- A new `start` is accepted in the cycle `done`=1, giving back-to-back throughput of one operation per `width`+1 cycles.
- `div_by_zero` clears at the edge that accepts the next `start`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` exactly 33 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for 32 sampled cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234, `div_by_zero`=1 with `done`. Next MULTU 2×3 clears the flag at its start edge.
- Pulse `start` and `hi_we` while busy → both ignored; in-flight result is intact. MTLO 0xDEAD when idle → LO=0xDEAD next cycle.
- Assert `reset` at cycle 10 of a DIV → `busy`, `done`, HI and LO are 0 the next cycle; no `done` pulse ever appears for the aborted op.

Source files
------------

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/result bundle for muldiv_unit.
//               master : issues start/op/a/b and MTHI/MTLO writes,
//                        observes busy/done/hi/lo/div_by_zero.
//               slave  : the multiply/divide unit itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               MULT/MULTU use an LSB-first shift-add, DIV/DIVU a restoring
//               shift-subtract; one step per cycle for WIDTH cycles, then a
//               single sign fix-up cycle.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               bus (slave)        - start/op/a/b request, hi_we/lo_we/wdata
//                                    MTHI/MTLO writes, busy/done handshake,
//                                    hi/lo results, div_by_zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic  clock,
    input  wire logic  reset,
    muldiv_if.slave    bus
);

    localparam int               c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [WIDTH-1:0]     r_orig_a;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_b_zero;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dbz;

    // ------------------------------------------------------------------
    // Operand capture: signed ops (op[0]=0) latch absolute values.
    // ------------------------------------------------------------------
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    always_comb begin
        w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
        w_mag_a = w_a_neg ? (~bus.a + 1'b1) : bus.a;
        w_mag_b = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // ------------------------------------------------------------------
    // One iteration step. r_acc is shared by both algorithms:
    //   multiply: {partial product, remaining multiplier bits}
    //   divide  : {partial remainder, remaining dividend / quotient bits}
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_div_next;

    always_comb begin
        w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

        // The remainder is kept below the divisor, so the shifted value
        // needs one extra bit before the trial subtraction.
        w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
        w_trial    = w_shift - {1'b0, r_mag_b};
        w_q_bit    = ~w_trial[WIDTH];
        w_rem_new  = w_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_q_bit};
    end

    // ------------------------------------------------------------------
    // Sign fix-up applied in FINISH. Negation wraps modulo 2^n, which is
    // what makes 0x80000000 / -1 come out as 0x80000000.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_prod = r_acc;
        w_quo  = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];
        if ((r_op == 2'b00) && (r_sign_a ^ r_sign_b)) begin
            w_prod = ~r_acc + 1'b1;
        end
        if ((r_op == 2'b10) && (r_sign_a ^ r_sign_b)) begin
            w_quo = ~r_acc[WIDTH-1:0] + 1'b1;
        end
        if ((r_op == 2'b10) && r_sign_a) begin
            w_rem = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_orig_a <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_orig_a <= bus.a;
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_b_zero <= (bus.b == '0);
                        r_cnt    <= '0;
                        // Divide walks the dividend, multiply the multiplier.
                        r_acc    <= bus.op[1] ? {{WIDTH{1'b0}}, w_mag_a}
                                              : {{WIDTH{1'b0}}, w_mag_b};
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_state  <= S_RUN;
                    end else begin
                        if (bus.hi_we) begin
                            r_hi <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            r_lo <= bus.wdata;
                        end
                    end
                end

                S_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_step) begin
                        r_state <= S_FINISH;
                    end
                end

                S_FINISH: begin
                    if (!r_op[1]) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_b_zero) begin
                        r_hi  <= r_orig_a;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed vector table,
//               randomized operations against an arithmetic reference model,
//               and hand-written sequences for MTHI/MTLO, ignored starts,
//               divide-by-zero flag lifetime and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {dbz, hi, lo}.
    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        p;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        case (op)
            2'b00: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(a) * 64'(b);
                return {1'b0, p};
            end
            default: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                if (op == 2'b11) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_n++;
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none expected=done within 100 cycles");
        end
    endtask

    task automatic run_and_check(input string name, input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                                 input logic ed);
        int lat, bn;
        start_op(op, a, b);
        check({name, "_busy_at_start"}, 64'(bus.busy), 64'd1);
        check({name, "_dbz_at_start"}, 64'(bus.div_by_zero), 64'd0);
        wait_done(lat, bn);
        check({name, "_latency"}, 64'(lat), 64'(W + 1));
        check({name, "_busy_cycles"}, 64'(bn), 64'(W));
        check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({name, "_hi"}, 64'(bus.hi), 64'(eh));
        check({name, "_lo"}, 64'(bus.lo), 64'(el));
        check({name, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
    endtask

    vec_t vecs[13];

    initial begin
        int           lat, bn, done_seen;
        logic [2*W:0] m;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        int           sel;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};
        vecs[12] = '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed vectors, issued back-to-back (start in the done cycle).
        for (int i = 0; i < 13; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) rb = W'($urandom_range(1, 15));
            if (sel == 2) ra = 32'h80000000;
            if (sel == 3) rb = 32'hFFFFFFFF;
            m = model(rop, ra, rb);
            run_and_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb,
                          m[2*W-1:W], m[W-1:0], m[2*W]);
        end

        // Divide-by-zero flag holds while idle and clears on the next start.
        run_and_check("dbz_set", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1);
        @(posedge clock);
        #1;
        check("dbz_held_idle", 64'(bus.div_by_zero), 64'd1);
        run_and_check("dbz_clear_mul", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        // start and hi_we while busy are both ignored.
        start_op(2'b01, 32'd5, 32'd6);
        repeat (5) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hBAD;
        @(negedge clock);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        wait_done(lat, bn);
        check("busy_ignore_latency", 64'(lat), 64'd27);
        check("busy_ignore_hi", 64'(bus.hi), 64'd0);
        check("busy_ignore_lo", 64'(bus.lo), 64'd30);
        @(posedge clock);
        #1;
        check("busy_ignore_no_restart", 64'(bus.busy), 64'd0);

        // MTLO, then MTHI+MTLO together.
        @(negedge clock);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD;
        @(posedge clock);
        #1;
        bus.lo_we = 1'b0;
        check("mtlo_lo", 64'(bus.lo), 64'hDEAD);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd0);
        @(negedge clock);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1111;
        @(posedge clock);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthi_both_hi", 64'(bus.hi), 64'h1111);
        check("mtlo_both_lo", 64'(bus.lo), 64'h1111);

        // Start wins over a simultaneous write; HI/LO hold until done.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hFFFF;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("start_wins_hi_hold", 64'(bus.hi), 64'h1111);
        check("start_wins_lo_hold", 64'(bus.lo), 64'h1111);
        wait_done(lat, bn);
        check("start_wins_hi", 64'(bus.hi), 64'd0);
        check("start_wins_lo", 64'(bus.lo), 64'd6);

        // Reset during RUN aborts with no done pulse.
        start_op(2'b10, 32'd1000, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
